expr_tx: RTL and testbench
==========================

Name: expr_tx

Overview:
- Expression transmitter; the generating end of the ASCII arithmetic-expression byte stream the team's expression recognizer consumes.
- Accepts a parallel job of up to MAX_TERMS BCD operands plus operator selects.
- Serializes it one ASCII byte per accepted transfer in the form digit (op digit)*, with op in {'+','*'}.
- Sits between a test/command source and any byte-stream consumer; valid/ready on the output side.

Parameters:
- MAX_TERMS, 4, maximum operand count per job; legal range 2..15.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- len  in  4  operand count for this job; legal 1..MAX_TERMS.
- digits  in  4*MAX_TERMS  BCD operands; operand i at bits [4i+3:4i]; operand 0 is sent first.
- ops  in  MAX_TERMS-1  operator i sits between operands i and i+1; 0='+' (8'h2B), 1='*' (8'h2A).
- out  out  8  ASCII byte.
- out_valid  out  1  out holds a byte.
- out_ready  in  1  consumer accepts the byte.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse after the final byte is accepted.
- err  out  1  one-cycle pulse when a job is rejected.

Behaviour:
- Reset (clr=1, async): state=IDLE; out=8'h00, out_valid=0, busy=0, done=0, err=0; all internal registers cleared.
- clr mid-job aborts immediately. No further bytes or done pulse. The partial stream is the consumer's problem.
- FSM states: IDLE, DIGIT, OP, EOL (only with the optional feature), FIN.
- Job start, IDLE with start=1:
  - Validate the job: len in 1..MAX_TERMS, and every operand with index < len is <= 9. Operands at index >= len and unused ops bits are ignored.
  - Invalid job: err=1 for the next cycle only; stay in IDLE; nothing emitted.
  - Valid job: capture len, digits and ops into internal registers; go to DIGIT; busy=1.
  - In the next cycle: out_valid=1, out=8'h30+digit0. Start-to-first-byte latency is 1 cycle.
- Transfer occurs on any edge with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out stays stable.
  - After a transfer, the next byte appears the following cycle, so back-to-back transfers run at 1 byte/cycle with out_valid held high.
- DIGIT, on transfer:
  - If operand index = len-1, go to FIN (or EOL).
  - Otherwise go to OP and present the ASCII code for ops[index].
- OP, on transfer: increment index, go to DIGIT, present 8'h30+digit[index].
- FIN: out_valid=0, done=1 for exactly one cycle, busy=0, return to IDLE.
- A start that coincides with the FIN cycle is ignored; it must be re-asserted in IDLE. start while busy is ignored.
- Inputs are captured at start; changing digits, ops or len mid-job has no effect.
- Byte count for a job is 2*len-1 (plus 1 with the optional feature). len=1 emits a single digit.
- out holds its last value while out_valid=0 (don't-care for consumers).

Optional Feature:
- Macro EXPR_TX_EOL_EN.
- Defined: after the final digit transfer, the FSM enters EOL and presents 8'h0A. Its transfer leads to FIN. This newline acts as a frame separator that returns the recognizer to its start state.
- Undefined: the EOL state and its logic are absent; the last digit transfer goes directly to FIN.

Decomposition:
- Package expr_pkg:
  - ASCII constants: CH_0=8'h30, CH_PLUS=8'h2B, CH_MUL=8'h2A, CH_LF=8'h0A.
  - FSM state encoding.
  - Operator encoding: OP_ADD=0, OP_MUL=1.
- Sub-module expr_char_enc, combinational: maps a 4-bit BCD value or an operator bit to an ASCII byte. Instantiated once in expr_tx.

Test Plan:
- Reset, then start with len=3, digits={..,4'd7,4'd2,4'd5}, ops=2'b10, out_ready tied 1:
  - Emits 8'h35, 8'h2B, 8'h32, 8'h2A, 8'h37 on 5 consecutive cycles.
  - done pulses once, then busy=0.
  - With EXPR_TX_EOL_EN, 8'h0A follows before done.
- len=1, digit0=9 -> single byte 8'h39, then done. len=0 or len=5 -> err pulse only, out_valid never 1.
- Invalid operand: len=2, digit1=4'hA -> err pulse, no bytes. Same digits with len=1 -> valid, byte 8'h30+digit0.
- Backpressure: out_ready toggles 1,0,0,1,...
  - out stays stable while stalled.
  - Total byte sequence matches the unstalled run.
  - No byte is duplicated or dropped.
- Assert clr during the 3rd byte of a 4-term job:
  - out_valid=0, busy=0 immediately with no clock edge required.
  - No done pulse.
  - A new job afterwards emits correctly from operand 0.
- start held high continuously across 2 jobs:
  - Second job begins only after returning to IDLE.
  - Inputs changed mid-job do not alter the bytes of the first job.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants and encodings for the expression transmitter slice.
// The EOL state exists only when EXPR_TX_EOL_EN is defined.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_LF   = 8'h0A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIGIT = 3'd1,
    ST_OP    = 3'd2,
`ifdef EXPR_TX_EOL_EN
    ST_EOL   = 3'd3,
`endif
    ST_FIN   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CK_DIGIT = 2'd0,
    CK_OP    = 2'd1,
    CK_LF    = 2'd2
  } char_kind_e;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational ASCII encoder: BCD digit, operator bit or line feed to one byte.
module expr_char_enc
  import expr_pkg::*;
(
  input  char_kind_e  kind_i,
  input  logic [3:0]  val_i,
  input  logic        op_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    unique case (kind_i)
      CK_DIGIT: byte_o = CH_0 + {4'h0, val_i};
      CK_OP:    byte_o = (op_i == OP_MUL) ? CH_MUL : CH_PLUS;
      CK_LF:    byte_o = CH_LF;
      default:  byte_o = CH_LF;
    endcase
  end

endmodule

// File: rtl/expr_tx.sv
// Expression transmitter: serializes a captured job as "digit (op digit)*" over valid/ready.
// Define EXPR_TX_EOL_EN to append a line feed frame separator after the last digit.
module expr_tx
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             len,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_e                  state_q;
  logic [3:0]              len_q;
  logic [4*MAX_TERMS-1:0]  digits_q;
  logic [MAX_TERMS-2:0]    ops_q;
  logic [3:0]              idx_q;
  logic [7:0]              out_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    job_ok;
  logic                    last;
  logic [3:0]              idx_d;
  char_kind_e              enc_kind;
  logic [3:0]              enc_val;
  logic                    enc_op;
  logic [7:0]              byte_d;

  assign last  = (idx_q == len_q - 4'd1);
  assign idx_d = idx_q + 4'd1;

  // Only operands the job actually uses must be valid BCD.
  always_comb begin
    job_ok = (len != 4'd0) && (int'(len) <= MAX_TERMS);
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (i < int'(len) && digits[4*i +: 4] > 4'd9) job_ok = 1'b0;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    enc_kind = CK_DIGIT;
    enc_val  = digits[3:0];
    enc_op   = OP_ADD;
    case (state_q)
      ST_DIGIT: begin
        enc_kind = CK_OP;
`ifdef EXPR_TX_EOL_EN
        if (last) enc_kind = CK_LF;
`endif
        for (int i = 0; i < MAX_TERMS-1; i++) begin
          if (idx_q == i[3:0]) enc_op = ops_q[i];
        end
      end
      ST_OP: begin
        enc_val = '0;
        for (int i = 0; i < MAX_TERMS; i++) begin
          if (idx_d == i[3:0]) enc_val = digits_q[4*i +: 4];
        end
      end
      default: ;
    endcase
  end

  expr_char_enc u_enc (
    .kind_i (enc_kind),
    .val_i  (enc_val),
    .op_i   (enc_op),
    .byte_o (byte_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      // NOTE: the captured job registers are cleared too, so an aborted job leaves nothing behind.
      state_q     <= ST_IDLE;
      len_q       <= '0;
      digits_q    <= '0;
      ops_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (job_ok) begin
              len_q       <= len;
              digits_q    <= digits;
              ops_q       <= ops;
              idx_q       <= '0;
              out_q       <= byte_d;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= ST_DIGIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DIGIT: begin
          if (out_ready) begin
            if (last) begin
`ifdef EXPR_TX_EOL_EN
              out_q       <= byte_d;
              state_q     <= ST_EOL;
`else
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_FIN;
`endif
            end else begin
              out_q   <= byte_d;
              state_q <= ST_OP;
            end
          end
        end
        ST_OP: begin
          if (out_ready) begin
            idx_q   <= idx_d;
            out_q   <= byte_d;
            state_q <= ST_DIGIT;
          end
        end
`ifdef EXPR_TX_EOL_EN
        ST_EOL: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_FIN;
          end
        end
`endif
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_expr_tx.sv
// Self-checking bench for expr_tx: a queue-based stream model checked every cycle plus literal byte logs.
// Honours EXPR_TX_EOL_EN the same way as the design.
module tb_expr_tx;

  localparam int MT = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic [3:0]      len;
  logic [4*MT-1:0] digits;
  logic [MT-2:0]   ops;
  logic [7:0]      out;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            err;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mq[$];
  logic [7:0] got[$];
  logic [7:0] exp_log[$];
  bit         exp_done = 1'b0;
  bit         exp_err  = 1'b0;
  int         done_cnt = 0;
  int         err_cnt  = 0;

  expr_tx #(.MAX_TERMS(MT)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .len       (len),
    .digits    (digits),
    .ops       (ops),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit job_ok(input logic [3:0] l, input logic [4*MT-1:0] d);
    if (l == 4'd0 || int'(l) > MT) return 1'b0;
    for (int i = 0; i < int'(l); i++)
      if (d[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Stream model: the queue head is the byte the DUT must be presenting this cycle.
  initial begin
    bit nd, ne;
    forever begin
      @(negedge clk);
      if (clr) begin
        mq.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
      end else begin
        check("out_valid", out_valid, mq.size() != 0);
        check("busy", busy, mq.size() != 0);
        check("done", done, exp_done);
        check("err", err, exp_err);
        if (mq.size() != 0) check("out", out, mq[0]);
        if (done) done_cnt++;
        if (err) err_cnt++;
        nd = 1'b0;
        ne = 1'b0;
        if (mq.size() != 0) begin
          if (out_ready) begin
            got.push_back(out);
            void'(mq.pop_front());
            if (mq.size() == 0) nd = 1'b1;
          end
        end else if (!exp_done && start) begin
          if (job_ok(len, digits)) begin
            for (int i = 0; i < int'(len); i++) begin
              mq.push_back(8'h30 + 8'(digits[4*i +: 4]));
              if (i < int'(len) - 1) mq.push_back(ops[i] ? 8'h2A : 8'h2B);
            end
`ifdef EXPR_TX_EOL_EN
            mq.push_back(8'h0A);
`endif
          end else begin
            ne = 1'b1;
          end
        end
        exp_done = nd;
        exp_err  = ne;
      end
    end
  end

  task automatic check_log(input string name);
    check({name, "_count"}, got.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < got.size(); i++)
      check({name, "_byte"}, got[i], exp_log[i]);
  endtask

  task automatic add_eol();
`ifdef EXPR_TX_EOL_EN
    exp_log.push_back(8'h0A);
`endif
  endtask

  task automatic expect_job_a();
    exp_log.delete();
    exp_log.push_back(8'h35); exp_log.push_back(8'h2B); exp_log.push_back(8'h32);
    exp_log.push_back(8'h2A); exp_log.push_back(8'h37);
    add_eol();
  endtask

  task automatic set_job(input logic [3:0] l, input logic [15:0] d, input logic [2:0] o);
    len    = l;
    digits = d;
    ops    = o;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating.
  task automatic wait_done(input int mode, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk); #1;
      out_ready = (mode == 0) || (k % 3 == 0);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic run_job(input logic [3:0] l, input logic [15:0] d, input logic [2:0] o,
                         input int mode, input bit valid);
    got.delete();
    done_cnt = 0;
    err_cnt  = 0;
    @(posedge clk); #1;
    set_job(l, d, o);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (valid) wait_done(mode, 100);
    else begin
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit seen;
    clr = 1'b0; start = 1'b0; out_ready = 1'b1;
    set_job(4'd0, 16'h0000, 3'b000);
    #1 clr = 1'b1;
    #1;
    check("rst_out", out, 8'h00);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // Basic job: 5+2*7
    run_job(4'd3, 16'h0725, 3'b010, 0, 1'b1);
    expect_job_a();
    check_log("jobA");
    check("jobA_done_cnt", done_cnt, 1);
    check("jobA_busy_after", busy, 0);

    run_job(4'd1, 16'h0009, 3'b000, 0, 1'b1);
    exp_log.delete(); exp_log.push_back(8'h39); add_eol();
    check_log("len1");
    check("len1_done_cnt", done_cnt, 1);

    run_job(4'd0, 16'h0725, 3'b010, 0, 1'b0);
    check("len0_err_cnt", err_cnt, 1);
    check("len0_bytes", got.size(), 0);
    run_job(4'd5, 16'h0725, 3'b010, 0, 1'b0);
    check("len5_err_cnt", err_cnt, 1);
    check("len5_bytes", got.size(), 0);

    run_job(4'd2, 16'h00A3, 3'b000, 0, 1'b0);
    check("baddig_err_cnt", err_cnt, 1);
    check("baddig_bytes", got.size(), 0);
    run_job(4'd1, 16'h00A3, 3'b000, 0, 1'b1);
    exp_log.delete(); exp_log.push_back(8'h33); add_eol();
    check_log("ignored_dig");
    check("ignored_dig_err_cnt", err_cnt, 0);

    // Backpressure must not change the byte sequence.
    run_job(4'd3, 16'h0725, 3'b010, 1, 1'b1);
    expect_job_a();
    check_log("bp");
    check("bp_done_cnt", done_cnt, 1);

    // Abort while the third byte of 1*2+3*4 is presented.
    got.delete(); done_cnt = 0;
    @(posedge clk); #1;
    set_job(4'd4, 16'h4321, 3'b101);
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_out", out, 8'h32);
    check("abort_pre_valid", out_valid, 1);
    clr = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out", out, 8'h00);
    @(posedge clk); #1 clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_done_cnt", done_cnt, 0);
    exp_log.delete(); exp_log.push_back(8'h31); exp_log.push_back(8'h2A);
    check_log("abort_partial");
    run_job(4'd3, 16'h0725, 3'b010, 0, 1'b1);
    expect_job_a();
    check_log("after_abort");

    // start held high across two jobs; inputs change during the first.
    got.delete(); done_cnt = 0;
    @(posedge clk); #1;
    set_job(4'd2, 16'h0081, 3'b001);
    start = 1'b1;
    @(posedge clk); #1;
    set_job(4'd3, 16'h0046, 3'b000);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("held_first_done", seen, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(0, 100);
    exp_log.delete();
    exp_log.push_back(8'h31); exp_log.push_back(8'h2A); exp_log.push_back(8'h38);
    add_eol();
    exp_log.push_back(8'h36); exp_log.push_back(8'h2B); exp_log.push_back(8'h34);
    exp_log.push_back(8'h2B); exp_log.push_back(8'h30);
    add_eol();
    check_log("held");
    check("held_done_cnt", done_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
